// File: rtl/pll_lock_supervisor_pkg.sv
// pll_sup_pkg: shared types and helpers for the PLL lock supervisor.
//   pll_state_e  - supervisor state encoding, also driven on the debug port
//                  'state'.
//   RETRY_W      - width of the retry_count output.
//   LOSS_W       - width of the lock_loss_count output.
//   timer_width  - width of the shared state timer, given the three timing
//                  parameters.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAILED    = 3'd4
  } pll_state_e;

  localparam int RETRY_W = 2;
  localparam int LOSS_W  = 8;

  // The timer holds a cycle count in the range 1..N, with 0 meaning "not yet
  // loaded", so it must be able to represent the largest N itself.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 1) return 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// pll_lock_supervisor_if: the signals between the supervisor and the
// SB_PLL40_CORE wrapper.
//   pll_lock   - PLL LOCK, driven by the PLL and asynchronous to the
//                supervisor clock.
//   pll_resetb - PLL RESETB, active-low, registered in the supervisor.
//   pll_bypass - PLL BYPASS, registered in the supervisor.
// There is no valid/ready handshake on this link: each signal is a level.
// The supervisor (master) drives the reset and bypass levels and only
// observes lock. The PLL side (slave) does the reverse.
interface pll_lock_supervisor_if;
  logic pll_lock;
  logic pll_resetb;
  logic pll_bypass;

  modport master (input pll_lock, output pll_resetb, output pll_bypass);
  modport slave  (output pll_lock, input pll_resetb, input pll_bypass);
endinterface

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// sync_2ff: a two-flop synchroniser for one asynchronous level.
// Ports:
//   clk - destination clock
//   rst - synchronous active-high reset; the output resets to 0
//   d   - asynchronous input
//   q   - synchronised output, lagging d by two clk cycles
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences an SB_PLL40_CORE from power-up to lock. It
// holds RESETB low, waits for LOCK with a timeout, retries, and falls back to
// FAILED (optionally with bypass). It releases the downstream sys_reset only
// after LOCK has been stable for STABLE_CYCLES.
// Ports:
//   clock_in        - free-running reference clock
//   reset           - synchronous, active-high
//   pll             - PLL link (lock in; resetb and bypass out)
//   relock_req      - single-cycle request to restart the sequence
//   sys_reset       - active-high reset for the PLL-clocked logic
//   ready           - high only in RUN
//   failed          - high only in FAILED
//   state           - current state encoding (debug)
//   retry_count     - attempts used in this sequence, saturating at 3
//   lock_loss_count - lock losses seen in RUN, saturating; cleared by reset
// All outputs are registered. They are decoded from the next state, so they
// change on the same edge as the state register.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RESET_CYCLES   = 16,
  parameter int LOCK_TIMEOUT   = 10000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 3,
  parameter bit BYPASS_ON_FAIL = 1'b1
) (
  input  logic                  clock_in,
  input  logic                  reset,
  pll_lock_supervisor_if.master pll,
  input  logic                  relock_req,
  output logic                  sys_reset,
  output logic                  ready,
  output logic                  failed,
  output logic [2:0]            state,
  output logic [RETRY_W-1:0]    retry_count,
  output logic [LOSS_W-1:0]     lock_loss_count
);

  localparam int TW = timer_width(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  // The internal retry counter must reach MAX_RETRIES even when that is
  // larger than the saturating 2-bit output.
  localparam int RC_RAW = $clog2(MAX_RETRIES + 2);
  localparam int RC_W   = (RC_RAW < 2) ? 2 : RC_RAW;

  pll_state_e           cur_state, next_state;
  logic [TW-1:0]        timer, timer_d, cur_dur, timer_dec;
  logic [RC_W-1:0]      retries, retries_d;
  logic [LOSS_W-1:0]    loss_d;
  logic                 lock_s, expired, reload;
  logic                 resetb_d, bypass_d, sys_reset_d, ready_d, failed_d;
  logic [RETRY_W-1:0]   retry_count_d;

  sync_2ff u_lock_sync (
    .clk (clock_in),
    .rst (reset),
    .d   (pll.pll_lock),
    .q   (lock_s)
  );

  function automatic logic [TW-1:0] state_dur(input pll_state_e s);
    case (s)
      RESET_PLL: return TW'(RESET_CYCLES);
      WAIT_LOCK: return TW'(LOCK_TIMEOUT);
      STABLE:    return TW'(STABLE_CYCLES);
      default:   return '0;
    endcase
  endfunction

  assign state = cur_state;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      cur_state       <= RESET_PLL;
      timer           <= '0;
      retries         <= '0;
      lock_loss_count <= '0;
      pll.pll_resetb  <= 1'b0;
      pll.pll_bypass  <= 1'b0;
      sys_reset       <= 1'b1;
      ready           <= 1'b0;
      failed          <= 1'b0;
      retry_count     <= '0;
    end else begin
      cur_state       <= next_state;
      timer           <= timer_d;
      retries         <= retries_d;
      lock_loss_count <= loss_d;
      pll.pll_resetb  <= resetb_d;
      pll.pll_bypass  <= bypass_d;
      sys_reset       <= sys_reset_d;
      ready           <= ready_d;
      failed          <= failed_d;
      retry_count     <= retry_count_d;
    end
  end

  // Timer: loaded with N on state entry and expiring on the cycle it reads 1,
  // so a state lasts exactly N cycles. Zero appears only after reset. The
  // first cycle in that case counts as cycle 1 of RESET_PLL.
  always_comb begin
    cur_dur   = state_dur(cur_state);
    expired   = (timer == TW'(1)) || ((timer == '0) && (cur_dur == TW'(1)));
    timer_dec = (timer == '0) ? (cur_dur - TW'(1)) : (timer - TW'(1));
  end

  always_comb begin
    next_state = cur_state;
    retries_d  = retries;
    loss_d     = lock_loss_count;
    reload     = 1'b0;

    if (relock_req) begin
      // Restart wins over every other event. A lock loss in the same RUN
      // cycle is still counted.
      next_state = RESET_PLL;
      reload     = 1'b1;
      retries_d  = '0;
      if ((cur_state == RUN) && !lock_s && (lock_loss_count != '1))
        loss_d = lock_loss_count + LOSS_W'(1);
    end else begin
      case (cur_state)
        RESET_PLL: begin
          if (expired) begin
            next_state = WAIT_LOCK;
            reload     = 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            next_state = STABLE;
            reload     = 1'b1;
          end else if (expired) begin
            reload = 1'b1;
            if (retries < RC_W'(MAX_RETRIES)) begin
              retries_d  = retries + RC_W'(1);
              next_state = RESET_PLL;
            end else begin
              next_state = FAILED;
            end
          end
        end
        STABLE: begin
          if (!lock_s) begin
            next_state = WAIT_LOCK;
            reload     = 1'b1;
          end else if (expired) begin
            next_state = RUN;
            reload     = 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            next_state = RESET_PLL;
            reload     = 1'b1;
            retries_d  = '0;
            if (lock_loss_count != '1)
              loss_d = lock_loss_count + LOSS_W'(1);
          end
        end
        FAILED: begin
          next_state = FAILED;
        end
        default: begin
          next_state = RESET_PLL;
          reload     = 1'b1;
          retries_d  = '0;
        end
      endcase
    end

    if (reload)
      timer_d = state_dur(next_state);
    else if ((cur_state == RUN) || (cur_state == FAILED))
      timer_d = timer;
    else
      timer_d = timer_dec;
  end

  // Output decode from the next state, registered above.
  always_comb begin
    resetb_d      = (next_state == WAIT_LOCK) || (next_state == STABLE) ||
                    (next_state == RUN);
    bypass_d      = (next_state == FAILED) && BYPASS_ON_FAIL;
    sys_reset_d   = !((next_state == RUN) ||
                      ((next_state == FAILED) && BYPASS_ON_FAIL));
    ready_d       = (next_state == RUN);
    failed_d      = (next_state == FAILED);
    retry_count_d = (retries_d >= RC_W'(3)) ? 2'd3 : retries_d[1:0];
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed testbench for pll_lock_supervisor with small timing parameters.
module tb_pll_lock_supervisor;
  import pll_sup_pkg::*;

  logic       clock_in;
  logic       reset;
  logic       relock_req;
  logic       sys_reset, ready, failed;
  logic [2:0] state;
  logic [1:0] retry_count;
  logic [7:0] lock_loss_count;
  int         errors;
  int         checks;

  pll_lock_supervisor_if pll_if ();

  pll_lock_supervisor #(
    .RESET_CYCLES   (4),
    .LOCK_TIMEOUT   (20),
    .STABLE_CYCLES  (8),
    .MAX_RETRIES    (2),
    .BYPASS_ON_FAIL (1'b1)
  ) dut (
    .clock_in        (clock_in),
    .reset           (reset),
    .pll             (pll_if.master),
    .relock_req      (relock_req),
    .sys_reset       (sys_reset),
    .ready           (ready),
    .failed          (failed),
    .state           (state),
    .retry_count     (retry_count),
    .lock_loss_count (lock_loss_count)
  );

  // Output vector layout: {state, resetb, bypass, sys_reset, ready, failed, retry_count}
  localparam logic [9:0] V_RESET  = {3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
  localparam logic [9:0] V_RUN    = {3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
  localparam logic [9:0] V_FAILED = {3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2};

  // clock / reset
  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] obs();
    return {state, pll_if.pll_resetb, pll_if.pll_bypass, sys_reset, ready, failed, retry_count};
  endfunction

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clock_in);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    relock_req = 1'b0;
    pll_if.pll_lock = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1;
    relock_req = 1'b0;
    pll_if.pll_lock = 1'b0;
    tick(3);
    checks++;
    if (obs() !== V_RESET) begin
      errors++;
      $display("FAIL reset_outputs: got %h exp %h", obs(), V_RESET);
    end
    checks++;
    if (lock_loss_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_loss: got %0d exp 0", lock_loss_count);
    end
  endtask

  task automatic test_nominal();
    int n;
    reset = 1'b0;
    n = 0;
    while (pll_if.pll_resetb === 1'b0 && n < 50) begin
      n++;
      tick(1);
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL nominal_resetb_low: got %0d cycles exp 4", n);
    end
    tick(10);
    pll_if.pll_lock = 1'b1;
    // 2 sync flops + 1 WAIT_LOCK decision + 8 STABLE cycles
    n = 0;
    do begin
      tick(1);
      n++;
    end while (sys_reset === 1'b1 && n < 50);
    checks++;
    if (n != 11) begin
      errors++;
      $display("FAIL nominal_sys_reset_latency: got %0d exp 11", n);
    end
    checks++;
    if (obs() !== V_RUN) begin
      errors++;
      $display("FAIL nominal_run_outputs: got %h exp %h", obs(), V_RUN);
    end
  endtask

  task automatic test_relock_run();
    pll_if.pll_lock = 1'b0;
    tick(2);
    // lock_s has just fallen; FSM still in RUN for this cycle
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL relock_run_pre_ready: got %b exp 1", ready);
    end
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    checks++;
    if (obs() !== V_RESET || lock_loss_count !== 8'd1) begin
      errors++;
      $display("FAIL relock_run: got %h loss %0d exp %h loss 1", obs(), lock_loss_count, V_RESET);
    end
    tick(3);
    checks++;
    if (lock_loss_count !== 8'd1) begin
      errors++;
      $display("FAIL relock_run_single_count: got %0d exp 1", lock_loss_count);
    end
  endtask

  task automatic test_timeout_fail();
    int n;
    do_reset();
    for (int a = 0; a < 3; a++) begin
      checks++;
      if (retry_count !== 2'(a)) begin
        errors++;
        $display("FAIL timeout_retry_count[%0d]: got %0d exp %0d", a, retry_count, a);
      end
      n = 0;
      while (pll_if.pll_resetb === 1'b0 && n < 50) begin
        n++;
        tick(1);
      end
      checks++;
      if (n != 4) begin
        errors++;
        $display("FAIL timeout_resetb_low[%0d]: got %0d exp 4", a, n);
      end
      n = 0;
      while (pll_if.pll_resetb === 1'b1 && n < 50) begin
        n++;
        tick(1);
      end
      checks++;
      if (n != 20) begin
        errors++;
        $display("FAIL timeout_resetb_high[%0d]: got %0d exp 20", a, n);
      end
    end
    checks++;
    if (obs() !== V_FAILED) begin
      errors++;
      $display("FAIL failed_outputs: got %h exp %h", obs(), V_FAILED);
    end
    tick(5);
    checks++;
    if (obs() !== V_FAILED) begin
      errors++;
      $display("FAIL failed_hold: got %h exp %h", obs(), V_FAILED);
    end
  endtask

  task automatic test_relock_failed();
    int n;
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    checks++;
    if (obs() !== V_RESET) begin
      errors++;
      $display("FAIL relock_failed: got %h exp %h", obs(), V_RESET);
    end
    n = 0;
    while (pll_if.pll_resetb === 1'b0 && n < 50) begin
      n++;
      tick(1);
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL relock_failed_resetb_low: got %0d exp 4", n);
    end
  endtask

  task automatic test_glitch();
    int n;
    do_reset();
    n = 0;
    while (retry_count !== 2'd1 && n < 100) begin
      n++;
      tick(1);
    end
    while (pll_if.pll_resetb !== 1'b1 && n < 150) begin
      n++;
      tick(1);
    end
    pll_if.pll_lock = 1'b1;
    while (state !== 3'd2 && n < 200) begin
      n++;
      tick(1);
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL glitch_reach_stable: got state %0d exp 2", state);
    end
    tick(4);
    pll_if.pll_lock = 1'b0;
    tick(3);
    checks++;
    if (state !== 3'd1 || retry_count !== 2'd1) begin
      errors++;
      $display("FAIL glitch_back_to_wait: got state %0d retry %0d exp state 1 retry 1", state, retry_count);
    end
    pll_if.pll_lock = 1'b1;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (state !== 3'd3 && n < 50);
    checks++;
    if (n != 11 || retry_count !== 2'd1) begin
      errors++;
      $display("FAIL glitch_fresh_stable: got %0d cycles retry %0d exp 11 cycles retry 1", n, retry_count);
    end
  endtask

  task automatic test_lock_loss();
    int n;
    do_reset();
    pll_if.pll_lock = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 50) begin
      n++;
      tick(1);
    end
    pll_if.pll_lock = 1'b0;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!(sys_reset === 1'b1 && ready === 1'b0) && n < 10);
    checks++;
    if (n != 3 || lock_loss_count !== 8'd1) begin
      errors++;
      $display("FAIL lock_loss_first: got %0d cycles loss %0d exp 3 cycles loss 1", n, lock_loss_count);
    end
    for (int i = 1; i < 260; i++) begin
      pll_if.pll_lock = 1'b1;
      n = 0;
      while (ready !== 1'b1 && n < 50) begin
        n++;
        tick(1);
      end
      if (n >= 50) begin
        checks++;
        errors++;
        $display("FAIL lock_loss_relock[%0d]: ready not reached", i);
        break;
      end
      pll_if.pll_lock = 1'b0;
      n = 0;
      while (ready !== 1'b0 && n < 10) begin
        n++;
        tick(1);
      end
      if (i == 253) begin
        checks++;
        if (lock_loss_count !== 8'd254) begin
          errors++;
          $display("FAIL lock_loss_254: got %0d exp 254", lock_loss_count);
        end
      end
      if (i == 254) begin
        checks++;
        if (lock_loss_count !== 8'd255) begin
          errors++;
          $display("FAIL lock_loss_255: got %0d exp 255", lock_loss_count);
        end
      end
    end
    checks++;
    if (lock_loss_count !== 8'd255) begin
      errors++;
      $display("FAIL lock_loss_saturate: got %0d exp 255", lock_loss_count);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    pll_if.pll_lock = 1'b1;
    n = 0;
    while (state !== 3'd2 && n < 50) begin
      n++;
      tick(1);
    end
    tick(2);
    reset = 1'b1;
    tick(1);
    checks++;
    if (obs() !== V_RESET || lock_loss_count !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: got %h loss %0d exp %h loss 0", obs(), lock_loss_count, V_RESET);
    end
    reset = 1'b0;
  endtask

  // sequence and final report
  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_nominal();
    test_relock_run();
    test_timeout_fail();
    test_relock_failed();
    test_glitch();
    test_lock_loss();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
